// File: rtl/mc_bus_pkg.sv
// Shared constants, state encoding and helpers for the Monte-Carlo bus master.
// Op index doubles as the bus address for every transfer.
package mc_bus_pkg;

  localparam int unsigned OP_W = 6;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t BOARD_BASE  = 6'd0;
  localparam op_t SEED_ADDR   = 6'd16;
  localparam op_t STAT_BASE   = 6'd17;
  localparam op_t STAT_STRIDE = 6'd10;
  localparam int unsigned NUM_AGENTS = 4;
  localparam op_t LAST_OP     = 6'd56;

  localparam logic [3:0] MAX_OFF   = 4'd0;
  localparam logic [3:0] TOTAL_OFF = 4'd2;
  localparam logic [3:0] TRIAL_OFF = 4'd6;

  typedef enum logic [2:0] {
    StIdle, StReq, StXfer, StRdWait, StRun, StCmp, StDone
  } mc_state_e;

  // The responder treats a zero seed as its own reset.
  function automatic logic [7:0] fix_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  function automatic logic [1:0] stat_agent(input op_t op);
    op_t idx;
    idx = op - STAT_BASE;
    return 2'(idx / STAT_STRIDE);
  endfunction

  function automatic logic [3:0] stat_off(input op_t op);
    op_t idx;
    idx = op - STAT_BASE;
    return 4'(idx % STAT_STRIDE);
  endfunction

endpackage

// File: rtl/mc_bus_master_unpack.sv
// Reassembles little-endian per-agent statistics from the read byte stream.
// Max/trial fields are kept only when MC_BUS_MASTER_STATS_EN is defined.
module mc_stat_unpack
  import mc_bus_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         we_i,
  input  logic [1:0]                   agent_i,
  input  logic [3:0]                   off_i,
  input  logic [7:0]                   data_i,
  output logic [NUM_AGENTS-1:0][31:0]  total_o
`ifdef MC_BUS_MASTER_STATS_EN
  ,
  output logic [NUM_AGENTS-1:0][15:0]  max_o,
  output logic [NUM_AGENTS-1:0][31:0]  trial_o
`endif
);

  logic [NUM_AGENTS-1:0][31:0] total_q, total_d;
  logic [1:0]                  tot_sel;

  assign tot_sel = 2'(off_i - TOTAL_OFF);

  always_comb begin
    total_d = total_q;
    if (we_i && off_i >= TOTAL_OFF && off_i < TRIAL_OFF) begin
      total_d[agent_i][tot_sel*8 +: 8] = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) total_q <= '0;
    else         total_q <= total_d;
  end

  assign total_o = total_q;

`ifdef MC_BUS_MASTER_STATS_EN
  logic [NUM_AGENTS-1:0][15:0] max_q, max_d;
  logic [NUM_AGENTS-1:0][31:0] trial_q, trial_d;
  logic                        max_sel;
  logic [1:0]                  trial_sel;

  assign max_sel   = 1'(off_i - MAX_OFF);
  assign trial_sel = 2'(off_i - TRIAL_OFF);

  always_comb begin
    max_d   = max_q;
    trial_d = trial_q;
    if (we_i && off_i < TOTAL_OFF) max_d[agent_i][max_sel*8 +: 8] = data_i;
    if (we_i && off_i >= TRIAL_OFF) trial_d[agent_i][trial_sel*8 +: 8] = data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_q   <= '0;
      trial_q <= '0;
    end else begin
      max_q   <= max_d;
      trial_q <= trial_d;
    end
  end

  assign max_o   = max_q;
  assign trial_o = trial_q;
`endif

endmodule

// File: rtl/mc_bus_master.sv
// Standalone initiator: loads board and seed into the responder, waits, reads
// back agent statistics and reports the best agent. MC_BUS_MASTER_STATS_EN adds stats_flat.
module mc_bus_master
  import mc_bus_pkg::*;
#(
  parameter int unsigned CELL_W     = 5,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned RUN_CYCLES = 1000000,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [16*CELL_W-1:0]  board,
  input  logic [7:0]            seed,
  output logic                  int_req,
  input  logic                  int_gnt,
  output logic [ADDR_W-1:0]     int_address,
  output logic [7:0]            int_wr_data,
  output logic                  int_write,
  output logic                  int_read,
  input  logic [7:0]            int_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            best_dir,
  output logic [31:0]           best_total
`ifdef MC_BUS_MASTER_STATS_EN
  ,
  output logic [4*80-1:0]       stats_flat
`endif
);

  mc_state_e             state_q, state_d;
  op_t                   op_q, op_d, launch_op;
  logic [16*CELL_W-1:0]  board_q, board_d;
  logic [7:0]            seed_q, seed_d;
  logic [31:0]           run_cnt_q, run_cnt_d, lat_q, lat_d;
  logic [1:0]            cmp_q, cmp_d, best_idx_q, best_idx_d, cand_idx;
  logic [31:0]           best_val_q, best_val_d, cand_val;
  logic                  req_q, req_d, wr_q, wr_d, rd_q, rd_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [1:0]            dir_q, dir_d;
  logic [31:0]           total_q, total_d;
  logic                  stat_we, launch;
  logic [3:0]            cell_idx;
  logic [NUM_AGENTS-1:0][31:0] agent_total;

`ifdef MC_BUS_MASTER_STATS_EN
  logic [NUM_AGENTS-1:0][15:0] agent_max;
  logic [NUM_AGENTS-1:0][31:0] agent_trial;
  logic [4*80-1:0]             stats_q, stats_d;
`endif

  mc_stat_unpack u_unpack (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (stat_we),
    .agent_i (stat_agent(op_q)),
    .off_i   (stat_off(op_q)),
    .data_i  (int_rd_data),
    .total_o (agent_total)
`ifdef MC_BUS_MASTER_STATS_EN
    ,
    .max_o   (agent_max),
    .trial_o (agent_trial)
`endif
  );

  assign cell_idx = 4'(launch_op - BOARD_BASE);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    board_d    = board_q;
    seed_d     = seed_q;
    run_cnt_d  = run_cnt_q;
    lat_d      = lat_q;
    cmp_d      = cmp_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    req_d      = req_q;
    addr_d     = '0;
    wdata_d    = '0;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dir_d      = dir_q;
    total_d    = total_q;
    stat_we    = 1'b0;
    launch     = 1'b0;
    launch_op  = op_q;
    cand_idx   = best_idx_q;
    cand_val   = best_val_q;
    if (agent_total[cmp_q] > best_val_q) begin
      cand_idx = cmp_q;
      cand_val = agent_total[cmp_q];
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          board_d = board;
          seed_d  = fix_seed(seed);
          busy_d  = 1'b1;
          req_d   = 1'b1;
          op_d    = BOARD_BASE;
          state_d = StReq;
        end
      end
      StReq: begin
        if (int_gnt) launch = 1'b1;
      end
      StXfer: begin
        if (rd_q) begin
          state_d = StRdWait;
          lat_d   = '0;
        end else if (op_q == SEED_ADDR) begin
          state_d   = StRun;
          req_d     = 1'b0;
          run_cnt_d = '0;
        end else begin
          launch    = 1'b1;
          launch_op = op_q + 6'd1;
        end
      end
      StRdWait: begin
        if (lat_q == READ_LAT - 1) begin
          stat_we = 1'b1;
          if (op_q == LAST_OP) begin
            state_d    = StCmp;
            req_d      = 1'b0;
            cmp_d      = '0;
            best_idx_d = '0;
            best_val_d = '0;
          end else begin
            launch    = 1'b1;
            launch_op = op_q + 6'd1;
          end
        end else begin
          lat_d = lat_q + 32'd1;
        end
      end
      StRun: begin
        if (run_cnt_q == RUN_CYCLES - 1) begin
          state_d = StReq;
          req_d   = 1'b1;
          op_d    = STAT_BASE;
        end else begin
          run_cnt_d = run_cnt_q + 32'd1;
        end
      end
      StCmp: begin
        best_idx_d = cand_idx;
        best_val_d = cand_val;
        cmp_d      = cmp_q + 2'd1;
        if (cmp_q == 2'd3) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          dir_d   = cand_idx;
          total_d = cand_val;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Issue the next op straight away when granted, otherwise park in REQ.
    if (launch) begin
      op_d = launch_op;
      if (int_gnt) begin
        state_d = StXfer;
        addr_d  = ADDR_W'(launch_op);
        if (launch_op <= SEED_ADDR) begin
          wr_d    = 1'b1;
          wdata_d = (launch_op == SEED_ADDR) ? seed_q
                                             : 8'(board_q[cell_idx*CELL_W +: CELL_W]);
        end else begin
          rd_d = 1'b1;
        end
      end else begin
        state_d = StReq;
      end
    end
  end

`ifdef MC_BUS_MASTER_STATS_EN
  always_comb begin
    stats_d = stats_q;
    if (state_q == StCmp && cmp_q == 2'd3) begin
      for (int k = 0; k < 4; k++) begin
        stats_d[k*80 +: 80] = {agent_trial[k], agent_total[k], agent_max[k]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stats_q <= '0;
    else      stats_q <= stats_d;
  end

  assign stats_flat = stats_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      board_q    <= '0;
      seed_q     <= '0;
      run_cnt_q  <= '0;
      lat_q      <= '0;
      cmp_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dir_q      <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      board_q    <= board_d;
      seed_q     <= seed_d;
      run_cnt_q  <= run_cnt_d;
      lat_q      <= lat_d;
      cmp_q      <= cmp_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dir_q      <= dir_d;
      total_q    <= total_d;
    end
  end

  assign int_req     = req_q;
  assign int_address = addr_q;
  assign int_wr_data = wdata_q;
  assign int_write   = wr_q;
  assign int_read    = rd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign best_dir    = dir_q;
  assign best_total  = total_q;

endmodule
